// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
//
// Shared types and constants for the 6502 stack push/pull engine.
//   stack_op_t          : command direction (PUSH writes downwards, PULL reads
//                         upwards from the current stack pointer).
//   stack_state_t       : sequencer states.
//   STACK_PAGE_DEFAULT  : high address byte of every stack access (page one).
// -----------------------------------------------------------------------------
package stack_pkg;

    typedef enum logic {
        PUSH = 1'b0,
        PULL = 1'b1
    } stack_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_PULL,
        S_CAPTURE,
        S_DONE
    } stack_state_t;

    localparam logic [7:0] STACK_PAGE_DEFAULT = 8'h01;

endpackage

// File: rtl/stack_addr_gen.sv
// -----------------------------------------------------------------------------
// stack_addr_gen
//
// Combinational stack address former shared by the push and pull paths.
// Produces {page, base - step} for PUSH and {page, base + step} for PULL.
// The offset wraps modulo 256, so the page byte never changes.
//
// Ports
//   page_i  [7:0]   high address byte
//   base_i  [7:0]   stack pointer the sequence started from
//   step_i  [1:0]   byte index within the sequence
//   op_i            PUSH (subtract) or PULL (add)
//   addr_o  [15:0]  full stack address
// -----------------------------------------------------------------------------
module stack_addr_gen
    import stack_pkg::*;
(
    input  logic [7:0]  page_i,
    input  logic [7:0]  base_i,
    input  logic [1:0]  step_i,
    input  stack_op_t   op_i,
    output logic [15:0] addr_o
);

    logic [7:0] offset;

    always_comb begin
        if (op_i == PULL) begin
            offset = base_i + {6'b0, step_i};
        end else begin
            offset = base_i - {6'b0, step_i};
        end
        addr_o = {page_i, offset};
    end

endmodule

// File: rtl/stack_sequencer.sv
// -----------------------------------------------------------------------------
// stack_sequencer
//
// Multi-byte stack push/pull engine for the 6502 core. Takes the current stack
// pointer at command accept, issues 1-3 page-one memory strobes, and returns
// the updated stack pointer with a one-cycle load pulse.
//
// Ports
//   phi2            system clock, rising edge
//   reset_N         synchronous active-low reset
//   cmd_valid       command request
//   cmd_ready       command accepted when high together with cmd_valid
//   cmd_op          0 = PUSH, 1 = PULL
//   cmd_count [1:0] byte count 0-3
//   push_data [23:0] byte k in [8k+7:8k], byte 0 pushed first
//   s_IN      [7:0] stack pointer sampled at accept
//   mem_addr  [15:0] stack address, 0 when no strobe
//   mem_wdata [7:0] write data, 0 when not writing
//   mem_write_EN    write strobe
//   mem_read_EN     read strobe, data returns on mem_rdata the next cycle
//   mem_rdata [7:0] read data
//   pull_data [23:0] pulled bytes, byte k = k-th byte pulled
//   pull_valid      one-cycle pulse at the end of a non-empty PULL
//   s_OUT     [7:0] updated stack pointer
//   s_load_EN       one-cycle pulse to load s_OUT into the stack pointer
//   busy            high whenever a sequence is in progress
// -----------------------------------------------------------------------------
module stack_sequencer
    import stack_pkg::*;
#(
    parameter logic [7:0] STACK_PAGE = STACK_PAGE_DEFAULT
) (
    input  logic        phi2,
    input  logic        reset_N,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [1:0]  cmd_count,
    input  logic [23:0] push_data,
    input  logic [7:0]  s_IN,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_write_EN,
    output logic        mem_read_EN,
    input  logic [7:0]  mem_rdata,
    output logic [23:0] pull_data,
    output logic        pull_valid,
    output logic [7:0]  s_OUT,
    output logic        s_load_EN,
    output logic        busy
);

    // Sequence state
    stack_state_t state_q;
    stack_op_t    op_q;
    logic [1:0]   n_q;
    logic [23:0]  push_q;
    logic [7:0]   s_q;
    // Index of the next strobe to issue. PULL counts 1..N and needs N+1 = 4.
    logic [2:0]   k_q;

    // Registered outputs
    logic [15:0]  addr_q;
    logic [7:0]   wdata_q;
    logic         we_q;
    logic         re_q;
    logic [23:0]  pull_q;
    logic         pvalid_q;
    logic [7:0]   sout_q;
    logic         sload_q;

    // Combinational helpers
    logic         idle;
    logic         accept;
    stack_op_t    gen_op;
    logic [7:0]   gen_base;
    logic [1:0]   gen_step;
    logic [15:0]  gen_addr;
    logic [1:0]   cap_idx;

    always_comb begin
        idle   = (state_q == S_IDLE);
        accept = cmd_valid && idle && reset_N;

        // In IDLE the first strobe is formed straight from the command so it
        // can be registered at the accept edge; afterwards from latched state.
        if (idle) begin
            gen_op   = stack_op_t'(cmd_op);
            gen_base = s_IN;
            gen_step = cmd_op ? 2'd1 : 2'd0;
        end else begin
            gen_op   = op_q;
            gen_base = s_q;
            gen_step = k_q[1:0];
        end

        // Read k-1 lands in byte k-2. While in PULL the read on the pins is
        // k_q-1, so the byte being captured is k_q-3 (2-bit wrap: 3->0, 4->1).
        // CAPTURE always collects the final byte N-1.
        if (state_q == S_CAPTURE) begin
            cap_idx = n_q - 2'd1;
        end else begin
            cap_idx = k_q[1:0] - 2'd3;
        end
    end

    stack_addr_gen u_addr_gen (
        .page_i (STACK_PAGE),
        .base_i (gen_base),
        .step_i (gen_step),
        .op_i   (gen_op),
        .addr_o (gen_addr)
    );

    always_ff @(posedge phi2) begin
        if (!reset_N) begin
            state_q  <= S_IDLE;
            op_q     <= PUSH;
            n_q      <= '0;
            push_q   <= '0;
            s_q      <= '0;
            k_q      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            pull_q   <= '0;
            pvalid_q <= 1'b0;
            sout_q   <= '0;
            sload_q  <= 1'b0;
        end else begin
            // Strobes and pulses last one cycle unless re-asserted below.
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            pvalid_q <= 1'b0;
            sload_q  <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q   <= stack_op_t'(cmd_op);
                        n_q    <= cmd_count;
                        push_q <= push_data;
                        s_q    <= s_IN;
                        if (stack_op_t'(cmd_op) == PULL) begin
                            pull_q <= '0;
                        end
                        if (cmd_count == 2'd0) begin
                            state_q <= S_DONE;
                            sload_q <= 1'b1;
                            sout_q  <= s_IN;
                        end else if (stack_op_t'(cmd_op) == PULL) begin
                            state_q <= S_PULL;
                            addr_q  <= gen_addr;
                            re_q    <= 1'b1;
                            k_q     <= 3'd2;
                        end else begin
                            state_q <= S_PUSH;
                            addr_q  <= gen_addr;
                            wdata_q <= push_data[7:0];
                            we_q    <= 1'b1;
                            k_q     <= 3'd1;
                        end
                    end
                end

                S_PUSH: begin
                    if (k_q == {1'b0, n_q}) begin
                        state_q <= S_DONE;
                        sload_q <= 1'b1;
                        sout_q  <= s_q - {6'b0, n_q};
                    end else begin
                        addr_q  <= gen_addr;
                        wdata_q <= push_q[{k_q[1:0], 3'b000} +: 8];
                        we_q    <= 1'b1;
                        k_q     <= k_q + 3'd1;
                    end
                end

                S_PULL: begin
                    if (k_q >= 3'd3) begin
                        pull_q[{cap_idx, 3'b000} +: 8] <= mem_rdata;
                    end
                    if (k_q == {1'b0, n_q} + 3'd1) begin
                        state_q <= S_CAPTURE;
                    end else begin
                        addr_q <= gen_addr;
                        re_q   <= 1'b1;
                        k_q    <= k_q + 3'd1;
                    end
                end

                S_CAPTURE: begin
                    pull_q[{cap_idx, 3'b000} +: 8] <= mem_rdata;
                    state_q  <= S_DONE;
                    sload_q  <= 1'b1;
                    pvalid_q <= 1'b1;
                    sout_q   <= s_q + {6'b0, n_q};
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready    = idle && reset_N;
    assign busy         = !idle;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_write_EN = we_q;
    assign mem_read_EN  = re_q;
    assign pull_data    = pull_q;
    assign pull_valid   = pvalid_q;
    assign s_OUT        = sout_q;
    assign s_load_EN    = sload_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stack_sequencer
//
// Scoreboard bench for stack_sequencer. The driver computes, for each
// accepted command, the list of expected memory strobes and the expected
// completion event from a byte-array model of page one; a monitor on the
// falling clock edge pops and compares whenever the DUT presents them.
// -----------------------------------------------------------------------------
module tb_stack_sequencer;

    logic        phi2 = 1'b0;
    logic        reset_N = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_op = 1'b0;
    logic [1:0]  cmd_count = 2'd0;
    logic [23:0] push_data = 24'h0;
    logic [7:0]  s_IN = 8'h0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_write_EN;
    logic        mem_read_EN;
    logic [7:0]  mem_rdata = 8'h0;
    logic [23:0] pull_data;
    logic        pull_valid;
    logic [7:0]  s_OUT;
    logic        s_load_EN;
    logic        busy;

    stack_sequencer #(.STACK_PAGE(8'h01)) dut (
        .phi2         (phi2),
        .reset_N      (reset_N),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_count    (cmd_count),
        .push_data    (push_data),
        .s_IN         (s_IN),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_write_EN (mem_write_EN),
        .mem_read_EN  (mem_read_EN),
        .mem_rdata    (mem_rdata),
        .pull_data    (pull_data),
        .pull_valid   (pull_valid),
        .s_OUT        (s_OUT),
        .s_load_EN    (s_load_EN),
        .busy         (busy)
    );

    always #5 phi2 = ~phi2;

    // Cycle counter (number of rising edges so far) and reset-at-last-edge.
    int   cyc = 0;
    logic rst_last = 1'b0;
    always @(posedge phi2) begin
        cyc      <= cyc + 1;
        rst_last <= !reset_N;
    end

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic        we;
        logic        re;
        logic [7:0]  wd;
    } strobe_t;

    typedef struct {
        int          cyc;
        logic [7:0]  s;
        logic        pv;
        logic [23:0] pd;
    } done_t;

    strobe_t    sq[$];
    done_t      dq[$];
    logic [7:0] exp_s = 8'h00;
    int         busy_from = 1;
    int         busy_until = 0;
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] ref_mem [256];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Page-one memory. Pins are sampled mid-cycle; read data is presented
    // during the cycle after the read strobe, junk otherwise.
    logic [7:0]  tb_mem [256];
    logic        prev_re = 1'b0;
    logic [7:0]  prev_off = 8'h0;
    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 8'(i * 37 + 11);
        forever begin
            @(negedge phi2);
            mem_rdata = prev_re ? tb_mem[prev_off] : 8'($urandom);
            if (mem_write_EN) tb_mem[mem_addr[7:0]] = mem_wdata;
            prev_re  = mem_read_EN;
            prev_off = mem_addr[7:0];
        end
    end

    // Monitor
    strobe_t m_st;
    done_t   m_dn;
    logic    m_busy;
    initial begin
        forever begin
            @(negedge phi2);
            if (rst_last) begin
                chk("rst_cmd_ready", 32'(cmd_ready), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_mem_addr", 32'(mem_addr), 0);
                chk("rst_mem_wdata", 32'(mem_wdata), 0);
                chk("rst_strobes", 32'({mem_write_EN, mem_read_EN}), 0);
                chk("rst_pull_data", 32'(pull_data), 0);
                chk("rst_pull_valid", 32'(pull_valid), 0);
                chk("rst_s_out", 32'(s_OUT), 0);
                chk("rst_s_load", 32'(s_load_EN), 0);
                sq.delete();
                dq.delete();
                exp_s      = 8'h00;
                busy_from  = 1;
                busy_until = 0;
            end else begin
                m_busy = (cyc >= busy_from) && (cyc <= busy_until);
                chk("busy", 32'(busy), 32'(m_busy));
                chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));

                if (mem_write_EN || mem_read_EN) begin
                    if (sq.size() == 0) begin
                        chk("strobe_unexpected", 32'({mem_write_EN, mem_read_EN}), 0);
                    end else begin
                        m_st = sq.pop_front();
                        chk("strobe_cycle", cyc, m_st.cyc);
                        chk("strobe_addr", 32'(mem_addr), 32'(m_st.addr));
                        chk("strobe_we", 32'(mem_write_EN), 32'(m_st.we));
                        chk("strobe_re", 32'(mem_read_EN), 32'(m_st.re));
                        chk("strobe_wdata", 32'(mem_wdata), 32'(m_st.wd));
                    end
                end else begin
                    chk("quiet_addr", 32'(mem_addr), 0);
                    chk("quiet_wdata", 32'(mem_wdata), 0);
                    if (sq.size() != 0 && sq[0].cyc <= cyc) begin
                        m_st = sq.pop_front();
                        chk("strobe_missing", 32'({mem_write_EN, mem_read_EN}), 32'({m_st.we, m_st.re}));
                    end
                end

                if (s_load_EN) begin
                    if (dq.size() == 0) begin
                        chk("done_unexpected", 32'(s_load_EN), 0);
                    end else begin
                        m_dn = dq.pop_front();
                        exp_s = m_dn.s;
                        chk("done_cycle", cyc, m_dn.cyc);
                        chk("done_s_out", 32'(s_OUT), 32'(m_dn.s));
                        chk("done_pull_valid", 32'(pull_valid), 32'(m_dn.pv));
                        if (m_dn.pv) chk("done_pull_data", 32'(pull_data), 32'(m_dn.pd));
                    end
                end else begin
                    chk("pull_valid_stray", 32'(pull_valid), 0);
                    chk("s_out_hold", 32'(s_OUT), 32'(exp_s));
                    if (dq.size() != 0 && dq[0].cyc <= cyc) begin
                        m_dn = dq.pop_front();
                        chk("done_missing", 32'(s_load_EN), 1);
                    end
                end
            end
        end
    end

    // Issue one command; expectations are queued just before the accept edge.
    // With hold set, cmd_valid stays high and the command inputs are scrambled
    // while the sequence runs.
    task automatic issue(input bit op, input int n, input logic [23:0] d,
                         input logic [7:0] s, input bit hold);
        int          a;
        int          waited;
        done_t       dn;
        logic [23:0] pd;
        logic [7:0]  off;
        @(negedge phi2); #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = 2'(n);
        push_data = d;
        s_IN      = s;
        waited    = 0;
        while (!cmd_ready && waited < 20) begin
            @(negedge phi2); #1;
            waited++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'(cmd_ready), 1);
            cmd_valid = 1'b0;
            return;
        end
        a  = cyc + 1;
        pd = '0;
        if (n == 0) begin
            dn = '{a, s, 1'b0, 24'h0};
        end else if (!op) begin
            for (int k = 0; k < n; k++) begin
                off = s - 8'(k);
                sq.push_back('{a + k, {8'h01, off}, 1'b1, 1'b0, d[8*k +: 8]});
                ref_mem[off] = d[8*k +: 8];
            end
            dn = '{a + n, s - 8'(n), 1'b0, 24'h0};
        end else begin
            for (int k = 1; k <= n; k++) begin
                off = s + 8'(k);
                sq.push_back('{a + k - 1, {8'h01, off}, 1'b0, 1'b1, 8'h00});
                pd[8*(k-1) +: 8] = ref_mem[off];
            end
            dn = '{a + n + 1, s + 8'(n), 1'b1, pd};
        end
        dq.push_back(dn);
        busy_from  = a;
        busy_until = dn.cyc;
        @(posedge phi2);
        @(negedge phi2); #1;
        if (hold) begin
            while (cyc < busy_until) begin
                s_IN      = 8'($urandom);
                push_data = 24'($urandom);
                cmd_count = 2'($urandom);
                cmd_op    = 1'($urandom);
                @(negedge phi2); #1;
            end
        end else begin
            cmd_valid = 1'b0;
            s_IN      = 8'($urandom);
            push_data = 24'($urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);

        repeat (3) @(negedge phi2);
        #1 reset_N = 1'b1;

        // Directed: three-byte push from FD.
        issue(1'b0, 3, 24'h30_12_34, 8'hFD, 1'b0);
        // Preload 01FB = 56, 01FC = 78 through the DUT, then pull them back.
        issue(1'b0, 2, 24'h00_56_78, 8'hFC, 1'b0);
        issue(1'b1, 2, 24'h0, 8'hFA, 1'b0);
        for (int i = 0; i < 10 && !pull_valid; i++) begin
            @(negedge phi2); #1;
        end
        chk("tp_pull_data", 32'(pull_data), 32'h0000_7856);
        chk("tp_pull_s_out", 32'(s_OUT), 32'h0000_00FC);

        // Wrap-around at both ends of the page.
        issue(1'b0, 3, 24'hA1_B2_C3, 8'h01, 1'b0);
        issue(1'b1, 2, 24'h0, 8'hFF, 1'b0);

        // Empty pull.
        issue(1'b1, 0, 24'h0, 8'h5A, 1'b0);

        // Back-to-back with cmd_valid held high and s_IN churning.
        issue(1'b0, 2, 24'h00_EE_DD, 8'h80, 1'b1);
        issue(1'b1, 1, 24'h0, 8'h7F, 1'b0);

        // Reset during the second read of a pull.
        issue(1'b1, 2, 24'h0, 8'hFA, 1'b0);
        @(negedge phi2); #1;
        reset_N = 1'b0;
        @(negedge phi2); #1;
        reset_N = 1'b1;
        #1;
        chk("ready_after_reset", 32'(cmd_ready), 1);

        // Randomized commands.
        for (int i = 0; i < 80; i++) begin
            issue(1'($urandom), int'($urandom_range(0, 3)), 24'($urandom),
                  8'($urandom), 1'($urandom));
        end
        cmd_valid = 1'b0;

        for (int i = 0; i < 20 && (sq.size() + dq.size()) != 0; i++) begin
            @(negedge phi2);
        end
        @(negedge phi2);
        chk("drain", 32'(sq.size() + dq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
